quad_demux_one_to_two: RTL and testbench
========================================

// Module: quad_demux_one_to_two
// PURPOSE
// - Registered quad 1-to-2 demultiplexer: the distribution end of the quad 2-to-1 selector path.
// - Accepts one WIDTH-bit word per handshake on D and routes it to output port A (S=0) or port B (S=1).
// - Each output port has a one-entry holding register with its own valid/ready handshake, so the two sinks drain independently.
// - Sits between a single lab data source and two downstream consumers. Counts the words delivered to each port.
// PARAMETERS
// - WIDTH  4  data word width (D, A, B)
// - CNT_W  8  width of the per-port accepted-word counters
// PORTS
// - CLK        in   1      single clock; all state updates on rising edge
// - RST_N      in   1      reset, asynchronous, active-low
// - D          in   WIDTH  input data word
// - S          in   1      route select: 0 -> port A, 1 -> port B
// - E          in   1      enable, active-low (0 = enabled)
// - IN_VALID   in   1      source has a word on D
// - IN_READY   out  1      block accepts D this cycle
// - A          out  WIDTH  port A data (holding register)
// - A_VALID    out  1      port A register full
// - A_READY    in   1      sink A takes the word
// - B          out  WIDTH  port B data (holding register)
// - B_VALID    out  1      port B register full
// - B_READY    in   1      sink B takes the word
// - A_CNT      out  CNT_W  words accepted for port A
// - B_CNT      out  CNT_W  words accepted for port B
// BEHAVIOUR
// - Reset (RST_N=0, async): A=B=0, A_VALID=B_VALID=0, A_CNT=B_CNT=0, internal select flag=0; IN_READY=0 while RST_N=0.
// - Target port T = A if sel=0 and B if sel=1. sel is S, or the internal flag under PING_PONG_EN.
// - IN_READY = ~E & (~T_VALID | T_READY). This is a combinational path from A_READY/B_READY and S. It is the only combinational path.
// - Accept = IN_VALID & IN_READY. On accept: T <= D, T_VALID <= 1, T_CNT <= T_CNT+1. Latency is 1 cycle (word visible on T the cycle after accept).
// - Drain: T_VALID & T_READY with no accept to T in the same cycle -> T_VALID <= 0. Data register holds its last value; it is never cleared.
// - Drain and refill of the same port in the same cycle: T_VALID stays 1 and T takes the new D. No bubble, no loss.
// - The non-target port is untouched by an accept. It drains independently per its own READY.
// - S and D are sampled only in the accept cycle. S changing while IN_VALID=1 and not accepted is legal; the value in the accept cycle wins.
// - E=1: IN_READY=0 and no accepts. Pending outputs still drain normally. Counters hold.
// - Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0) and do not saturate.
// - Both ports full with both READY=0: IN_READY=0 for either S. Source stalls.
// - Reset asserted mid-transfer: all state cleared immediately. Words held in A/B are discarded.
// CONFIGURATION
// - Macro PING_PONG_EN defined: S is ignored. The internal flag selects the target (reset 0 -> first word to A). The flag toggles on every accept, giving strict A,B,A,B alternation. When the target is full, the block stalls even if the other port is empty.
// - Macro not defined: the S port selects the target per word. No internal flag is implemented.
// TESTING
// - Reset: hold RST_N=0 with IN_VALID=1 and D=4'hF -> IN_READY=0, A=B=0, both VALID=0, both counts=0.
// - Basic route: E=0, A_READY=B_READY=1; send D=4'h5 with S=0, then D=4'hA with S=1 -> A=5 with A_VALID for 1 cycle, then B=A with B_VALID; A_CNT=1, B_CNT=1.
// - Backpressure: A_READY=0, send 4'h3 to A, then offer 4'h7 to A -> IN_READY=0 on the second word. Raise A_READY -> same-cycle drain/refill, A=7, A_VALID stays 1.
// - Enable: E=1, IN_VALID=1 for 5 cycles -> no accepts, counts unchanged. A pending B word still drains when B_READY=1.
// - Wrap: CNT_W=2, accept 5 words to B -> B_CNT sequence 1,2,3,0,1.
// - PING_PONG_EN: S held at 1, send 4 words 1,2,3,4 with both READY=1 -> A gets 1,3 and B gets 2,4. With A_READY=0 after word 1, word 3 stalls while B is empty.

Source files
------------

// File: rtl/quad_demux_one_to_two_if.sv
// Handshake bundle for quad_demux_one_to_two: one source port and two sink ports.
// master drives the source side and the sink READY lines; slave is the demux itself.
interface quad_demux_one_to_two_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] D;
    logic             S;
    logic             E;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] B;
    logic             B_VALID;
    logic             B_READY;
    logic [CNT_W-1:0] A_CNT;
    logic [CNT_W-1:0] B_CNT;

    modport master (
        output D, S, E, IN_VALID, A_READY, B_READY,
        input  IN_READY, A, A_VALID, B, B_VALID, A_CNT, B_CNT
    );

    modport slave (
        input  D, S, E, IN_VALID, A_READY, B_READY,
        output IN_READY, A, A_VALID, B, B_VALID, A_CNT, B_CNT
    );
endinterface

// File: rtl/quad_demux_one_to_two.sv
// Registered 1-to-2 demux with a one-entry holding register and word counter per port.
// Optional macro PING_PONG_EN: ignore S and alternate A,B,A,B using an internal flag.
module quad_demux_one_to_two #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic                    CLK,
    input logic                    RST_N,
    quad_demux_one_to_two_if.slave bus
);

    logic             sel;
    logic             tgt_free;
    logic             in_ready;
    logic             accept;
    logic             acc_a;
    logic             acc_b;

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

`ifdef PING_PONG_EN
    logic flag_q, flag_d;
    logic unused_s;

    assign sel      = flag_q;
    assign unused_s = bus.S;

    always_comb begin
        flag_d = flag_q;
        if (accept) begin
            flag_d = ~flag_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end
`else
    assign sel = bus.S;
`endif

    // A full target may still accept when its sink drains in the same cycle.
    always_comb begin
        tgt_free = sel ? (~b_valid_q | bus.B_READY) : (~a_valid_q | bus.A_READY);
        in_ready = RST_N & ~bus.E & tgt_free;
        accept   = bus.IN_VALID & in_ready;
        acc_a    = accept & ~sel;
        acc_b    = accept & sel;
    end

    always_comb begin
        a_data_d  = a_data_q;
        a_valid_d = a_valid_q;
        a_cnt_d   = a_cnt_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        b_cnt_d   = b_cnt_q;

        if (acc_a) begin
            a_data_d  = bus.D;
            a_valid_d = 1'b1;
            a_cnt_d   = a_cnt_q + CNT_W'(1);
        end else if (bus.A_READY) begin
            a_valid_d = 1'b0;
        end

        if (acc_b) begin
            b_data_d  = bus.D;
            b_valid_d = 1'b1;
            b_cnt_d   = b_cnt_q + CNT_W'(1);
        end else if (bus.B_READY) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_data_q  <= '0;
            a_valid_q <= 1'b0;
            a_cnt_q   <= '0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_cnt_q   <= '0;
        end else begin
            a_data_q  <= a_data_d;
            a_valid_q <= a_valid_d;
            a_cnt_q   <= a_cnt_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
            b_cnt_q   <= b_cnt_d;
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.A        = a_data_q;
    assign bus.A_VALID  = a_valid_q;
    assign bus.A_CNT    = a_cnt_q;
    assign bus.B        = b_data_q;
    assign bus.B_VALID  = b_valid_q;
    assign bus.B_CNT    = b_cnt_q;

endmodule

// File: tb/tb_quad_demux_one_to_two.sv
// Directed-vector bench for quad_demux_one_to_two, built with CNT_W=2 so counter wrap is reachable.
// Covers the default S-routed build; the PING_PONG_EN build runs its own alternation vectors.
module tb_quad_demux_one_to_two;

    logic CLK;
    logic RST_N;
    int   assertCount;
    int   failCount;

    quad_demux_one_to_two_if #(.WIDTH(4), .CNT_W(2)) busIf ();

    quad_demux_one_to_two #(.WIDTH(4), .CNT_W(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (busIf)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one full set of source/sink inputs, then let combinational IN_READY settle.
    task automatic applyStimulus(input logic [3:0] d, input logic s, input logic e,
                                 input logic inValid, input logic aReady, input logic bReady);
        busIf.D        = d;
        busIf.S        = s;
        busIf.E        = e;
        busIf.IN_VALID = inValid;
        busIf.A_READY  = aReady;
        busIf.B_READY  = bReady;
        #1;
    endtask

    // Advance past one rising edge so registered outputs are stable to sample.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Reset behaviour, then the directed scenarios for whichever build is compiled.
    initial begin
        int wrapExp[5];
        wrapExp = '{1, 2, 3, 0, 1};
        assertCount = 0;
        failCount   = 0;

        RST_N = 1'b0;
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("rstInReady", busIf.IN_READY, 0);
        checkOutput("rstA",       busIf.A, 0);
        checkOutput("rstB",       busIf.B, 0);
        checkOutput("rstAValid",  busIf.A_VALID, 0);
        checkOutput("rstBValid",  busIf.B_VALID, 0);
        checkOutput("rstACnt",    busIf.A_CNT, 0);
        checkOutput("rstBCnt",    busIf.B_CNT, 0);

        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        RST_N = 1'b1;
        stepCycle();

`ifdef PING_PONG_EN
        // S stuck at 1 must not matter: words alternate A,B,A,B.
        applyStimulus(4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("ppW1A",      busIf.A, 4'h1);
        checkOutput("ppW1AValid", busIf.A_VALID, 1);
        applyStimulus(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("ppW2B",      busIf.B, 4'h2);
        checkOutput("ppW2AValid", busIf.A_VALID, 0);
        applyStimulus(4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("ppW3A",      busIf.A, 4'h3);
        applyStimulus(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("ppW4B",      busIf.B, 4'h4);
        checkOutput("ppACnt",     busIf.A_CNT, 2);
        checkOutput("ppBCnt",     busIf.B_CNT, 2);

        // Stall on full A even though B empties.
        RST_N = 1'b0;
        #1;
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        RST_N = 1'b1;
        stepCycle();
        applyStimulus(4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        stepCycle();
        checkOutput("ppStallB",   busIf.B, 4'h2);
        applyStimulus(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ppStallRdy1", busIf.IN_READY, 0);
        stepCycle();
        checkOutput("ppBEmpty",   busIf.B_VALID, 0);
        checkOutput("ppStallRdy2", busIf.IN_READY, 0);
        checkOutput("ppStallA",   busIf.A, 4'h1);
`else
        // Basic routing: 5 to A, then A to B while A drains.
        applyStimulus(4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("basicRdyA",  busIf.IN_READY, 1);
        stepCycle();
        checkOutput("basicA",     busIf.A, 4'h5);
        checkOutput("basicAValid", busIf.A_VALID, 1);
        checkOutput("basicACnt",  busIf.A_CNT, 1);
        applyStimulus(4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("basicRdyB",  busIf.IN_READY, 1);
        stepCycle();
        checkOutput("basicADrain", busIf.A_VALID, 0);
        checkOutput("basicAHold", busIf.A, 4'h5);
        checkOutput("basicB",     busIf.B, 4'hA);
        checkOutput("basicBValid", busIf.B_VALID, 1);
        checkOutput("basicBCnt",  busIf.B_CNT, 1);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("basicBDrain", busIf.B_VALID, 0);

        // Backpressure on A, then same-cycle drain and refill.
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bpA3",       busIf.A, 4'h3);
        applyStimulus(4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bpRdyLow",   busIf.IN_READY, 0);
        stepCycle();
        checkOutput("bpAHeld",    busIf.A, 4'h3);
        checkOutput("bpACntHeld", busIf.A_CNT, 2);
        applyStimulus(4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("bpRdyHigh",  busIf.IN_READY, 1);
        stepCycle();
        checkOutput("bpRefillA",  busIf.A, 4'h7);
        checkOutput("bpRefillV",  busIf.A_VALID, 1);
        checkOutput("bpACnt",     busIf.A_CNT, 3);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("bpADrain",   busIf.A_VALID, 0);

        // Park a word in B, then hold E high for five cycles.
        applyStimulus(4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("enBCnt",     busIf.B_CNT, 2);
        applyStimulus(4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("enRdyLow",   busIf.IN_READY, 0);
        repeat (4) stepCycle();
        checkOutput("enBHeld",    busIf.B, 4'hC);
        checkOutput("enBValid",   busIf.B_VALID, 1);
        applyStimulus(4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("enRdyStill", busIf.IN_READY, 0);
        stepCycle();
        checkOutput("enBDrain",   busIf.B_VALID, 0);
        checkOutput("enACnt",     busIf.A_CNT, 3);
        checkOutput("enBCntHeld", busIf.B_CNT, 2);

        // Fill both ports; A_CNT wraps 3 -> 0, and the source stalls for either S.
        applyStimulus(4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("fullACntWrap", busIf.A_CNT, 0);
        applyStimulus(4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("fullBCnt",   busIf.B_CNT, 3);
        applyStimulus(4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fullRdyS0",  busIf.IN_READY, 0);
        applyStimulus(4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fullRdyS1",  busIf.IN_READY, 0);

        // Asynchronous reset mid-transfer discards both held words at once.
        RST_N = 1'b0;
        #1;
        checkOutput("midRstAValid", busIf.A_VALID, 0);
        checkOutput("midRstBValid", busIf.B_VALID, 0);
        checkOutput("midRstA",      busIf.A, 0);
        checkOutput("midRstBCnt",   busIf.B_CNT, 0);
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        RST_N = 1'b1;
        stepCycle();

        // Five back-to-back words to B: counter runs 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'(i + 8), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            stepCycle();
            checkOutput("wrapBCnt", busIf.B_CNT, wrapExp[i]);
            checkOutput("wrapBData", busIf.B, 32'(i + 8));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
